// File: rtl/snake_ctrl_input.sv
// Player input front end for the snake game: debounces the five buttons on a divided-clock strobe,
// runs the idle/run/pause state machine and turns arrow presses into one safe turn per move tick.
module snake_ctrl_input #(
  parameter int unsigned SAMPLE_BIT = 17,
  parameter int unsigned DB_LEN     = 4,
  parameter logic [1:0]  DIR_INIT   = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] clkdiv,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_start,
  input  logic        dir_commit,
  output logic [1:0]  dir,
  output logic [1:0]  dir_pend,
  output logic        start_pulse,
  output logic        running,
  output logic [4:0]  btn_db
);

  localparam logic [3:0] CntMax = 4'(DB_LEN - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  logic [4:0]      btn_raw;
  logic [4:0]      sync1_q, sync2_q;
  logic            bit_q;
  logic            samp_en;
  logic [4:0][3:0] cnt_q, cnt_d;
  logic [4:0]      level_q, level_d;
  logic [4:0]      level_prev_q;
  logic [4:0]      evt;
  state_e          state_q, state_d;
  logic [1:0]      dir_q, dir_d;
  logic [1:0]      pend_q, pend_d;
  logic [1:0]      next_dir;
  logic [1:0]      cand;
  logic            cand_vld;
  logic            unused_clkdiv;

  // Bit order {start, right, left, down, up} matches btn_db.
  assign btn_raw       = {btn_start, btn_right, btn_left, btn_down, btn_up};
  assign samp_en       = clkdiv[SAMPLE_BIT] & ~bit_q;
  assign unused_clkdiv = ^clkdiv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      bit_q        <= 1'b0;
      cnt_q        <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      state_q      <= StIdle;
      dir_q        <= DIR_INIT;
      pend_q       <= DIR_INIT;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      bit_q        <= clkdiv[SAMPLE_BIT];
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      state_q      <= state_d;
      dir_q        <= dir_d;
      pend_q       <= pend_d;
    end
  end

  // A sample matching the current level restarts the count, so short glitches never flip it.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (samp_en) begin
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntMax) begin
          level_d[i] = ~level_q[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  assign evt = level_q & ~level_prev_q;

  always_comb begin
    state_d = state_q;
    if (evt[4]) begin
      unique case (state_q)
        StIdle:  state_d = StRun;
        StRun:   state_d = StPause;
        StPause: state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  // Turns are validated against the direction that will be in force after this edge, so a press
  // coinciding with a commit is checked against the freshly committed heading.
  always_comb begin
    next_dir = (state_q == StRun && dir_commit) ? pend_q : dir_q;
    cand_vld = (state_q == StRun) && (|evt[3:0]);
    if (evt[0])      cand = 2'b00;
    else if (evt[1]) cand = 2'b01;
    else if (evt[2]) cand = 2'b10;
    else             cand = 2'b11;
    dir_d  = next_dir;
    pend_d = pend_q;
    if (cand_vld && (cand[1] != next_dir[1])) pend_d = cand;
  end

  assign dir         = dir_q;
  assign dir_pend    = pend_q;
  assign start_pulse = evt[4];
  assign running     = (state_q == StRun);
  assign btn_db      = level_q;

endmodule

// File: tb/tb_snake_ctrl_input.sv
// Directed bench for snake_ctrl_input with a fast strobe (bit 2 of a free-running counter).
module tb_snake_ctrl_input;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] clkdiv = '0;
  logic [4:0]  btn = '0;
  logic        dir_commit = 1'b0;
  logic [1:0]  dir, dir_pend;
  logic        start_pulse, running;
  logic [4:0]  btn_db;

  int n_checks = 0;
  int n_pass   = 0;
  int lat;

  snake_ctrl_input #(
    .SAMPLE_BIT(2),
    .DB_LEN    (4),
    .DIR_INIT  (2'b11)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clkdiv     (clkdiv),
    .btn_up     (btn[0]),
    .btn_down   (btn[1]),
    .btn_left   (btn[2]),
    .btn_right  (btn[3]),
    .btn_start  (btn[4]),
    .dir_commit (dir_commit),
    .dir        (dir),
    .dir_pend   (dir_pend),
    .start_pulse(start_pulse),
    .running    (running),
    .btn_db     (btn_db)
  );

  always #5 clk = ~clk;
  always @(posedge clk) clkdiv <= clkdiv + 32'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Hold a button until its debounced level rises; returns in the cycle its event is high.
  task automatic press(input int idx, output int n);
    btn[idx] = 1'b1;
    n = 0;
    while (n < 60 && btn_db[idx] !== 1'b1) begin
      tick();
      n++;
    end
    chk($sformatf("press_%0d_level", idx), {7'd0, btn_db[idx]}, 8'd1);
  endtask

  task automatic release_btn(input int idx);
    int n;
    btn[idx] = 1'b0;
    n = 0;
    while (n < 60 && btn_db[idx] !== 1'b0) begin
      tick();
      n++;
    end
    chk($sformatf("release_%0d_level", idx), {7'd0, btn_db[idx]}, 8'd0);
  endtask

  task automatic commit();
    dir_commit = 1'b1;
    tick();
    dir_commit = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dir"}, {6'd0, dir}, 8'h3);
    chk({tag, "_pend"}, {6'd0, dir_pend}, 8'h3);
    chk({tag, "_running"}, {7'd0, running}, 8'h0);
    chk({tag, "_btn_db"}, {3'd0, btn_db}, 8'h0);
    chk({tag, "_start_pulse"}, {7'd0, start_pulse}, 8'h0);
  endtask

  initial begin
    // Reset with the divider counting.
    repeat (5) tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();

    // Start press: level within 2 + 8 + 32 clk, one pulse, then RUN.
    press(4, lat);
    chk("start_latency_ok", {7'd0, lat <= 42}, 8'd1);
    chk("start_pulse_hi", {7'd0, start_pulse}, 8'd1);
    chk("still_idle", {7'd0, running}, 8'd0);
    tick();
    chk("start_pulse_lo", {7'd0, start_pulse}, 8'd0);
    chk("running_on", {7'd0, running}, 8'd1);
    release_btn(4);
    chk("release_no_toggle", {7'd0, running}, 8'd1);

    // 20-clk glitch on up: never reaches four strobes.
    btn[0] = 1'b1;
    repeat (20) tick();
    btn[0] = 1'b0;
    repeat (40) tick();
    chk("glitch_btn_db", {3'd0, btn_db}, 8'h0);
    chk("glitch_pend", {6'd0, dir_pend}, 8'h3);

    // Reversal rejection: left against right.
    press(2, lat);
    tick();
    chk("rev_left_pend", {6'd0, dir_pend}, 8'h3);
    release_btn(2);
    press(0, lat);
    tick();
    chk("up_pend", {6'd0, dir_pend}, 8'h0);
    chk("up_dir_held", {6'd0, dir}, 8'h3);
    release_btn(0);
    commit();
    chk("commit_up_dir", {6'd0, dir}, 8'h0);

    // Double turn in one tick: right then (up, left) against committed right.
    press(3, lat);
    tick();
    chk("right_pend", {6'd0, dir_pend}, 8'h3);
    release_btn(3);
    commit();
    chk("commit_right_dir", {6'd0, dir}, 8'h3);
    press(0, lat);
    tick();
    release_btn(0);
    press(2, lat);
    tick();
    chk("double_turn_pend", {6'd0, dir_pend}, 8'h0);
    release_btn(2);
    commit();
    chk("double_turn_dir", {6'd0, dir}, 8'h0);

    // Get to left, then up and down in the same cycle.
    press(2, lat);
    tick();
    release_btn(2);
    commit();
    chk("left_dir", {6'd0, dir}, 8'h2);
    btn[1:0] = 2'b11;
    lat = 0;
    while (lat < 60 && btn_db[0] !== 1'b1) begin
      tick();
      lat++;
    end
    chk("ud_same_cycle", {6'd0, btn_db[1:0]}, 8'h3);
    tick();
    chk("ud_priority_pend", {6'd0, dir_pend}, 8'h0);
    btn[1:0] = 2'b00;
    lat = 0;
    while (lat < 60 && btn_db[1:0] !== 2'b00) begin
      tick();
      lat++;
    end
    chk("ud_released", {6'd0, btn_db[1:0]}, 8'h0);

    // Down coincident with commit of up: reversal of the new heading.
    press(1, lat);
    commit();
    chk("sim_commit_dir", {6'd0, dir}, 8'h0);
    chk("sim_commit_pend", {6'd0, dir_pend}, 8'h0);
    release_btn(1);

    // Pending right, then pause: commit and arrows ignored.
    press(3, lat);
    tick();
    chk("pre_pause_pend", {6'd0, dir_pend}, 8'h3);
    release_btn(3);
    press(4, lat);
    chk("pause_pulse", {7'd0, start_pulse}, 8'd1);
    tick();
    chk("paused", {7'd0, running}, 8'd0);
    release_btn(4);
    commit();
    tick();
    chk("pause_commit_ignored", {6'd0, dir}, 8'h0);
    press(2, lat);
    tick();
    chk("pause_arrow_ignored", {6'd0, dir_pend}, 8'h3);
    release_btn(2);
    press(4, lat);
    tick();
    chk("resumed", {7'd0, running}, 8'd1);
    release_btn(4);

    // Reset mid-debounce, button held through reset.
    btn[0] = 1'b1;
    repeat (12) tick();
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    tick();
    tick();
    rst = 1'b0;
    press(0, lat);
    chk("held_fresh_pulse_idle", {7'd0, running}, 8'd0);
    tick();
    chk("held_idle_pend", {6'd0, dir_pend}, 8'h3);
    btn = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
